// File: rtl/sample_capture_pkg.sv
// Shared definitions for the sample capture buffer: widths, depth and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sample_capture_pkg;

  // Default sample width and address width; the depth is always a power of two.
  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  // Capture FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port sample store: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after re; it holds its value while re is low.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports: clk, rst_n (synchronous, resets only the read register, never the array),
//        we/waddr/wdata (write port), re/raddr (read request), rdata (registered read data).
module sample_capture_ram
  import sample_capture_pkg::*;
#(
  parameter int DW = sample_capture_pkg::DW,
  parameter int AW = sample_capture_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // The array has no reset so it maps onto block RAM; a captured record
  // survives a reset of the control logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only loads on a request, so the last read value is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Output register reset maps onto the block RAM output-register reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sample_capture_buf.sv
// One-shot capture of a full record of DDC samples, then random-access readback.
// Latency: a write lands on the edge it is presented; reads return one cycle after rd_en.
// Backpressure: none; samples outside a capture are dropped, reads outside FULL are ignored.
//
// Ports: clk, rst_n (synchronous, active-low); arm (start capture); din_valid/din (samples);
//        rd_en/rd_addr -> rd_valid/rd_data (readback, FULL only); busy (capturing);
//        done (complete record held).
module sample_capture_buf
  import sample_capture_pkg::*;
#(
  parameter int DW = sample_capture_pkg::DW,
  parameter int AW = sample_capture_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_en;
  logic          rd_fire;

  // Writes only while capturing; reads only while a full record is held.
  // A read issued together with a re-arm in FULL still completes because
  // rd_fire looks at the current state, not the next one.
  assign wr_en   = (state_q == ST_CAPTURE) && din_valid;
  assign rd_fire = (state_q == ST_FULL) && rd_en;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rd_valid_d = rd_fire;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      ST_CAPTURE: begin
        // arm is deliberately ignored here so a capture cannot be restarted.
        if (din_valid) begin
          // Increment wraps to zero naturally after the last address.
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (&wr_ptr_q) begin
            state_d = ST_FULL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_ptr_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sample_capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_fire),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sample_capture_buf.sv
// Directed self-checking bench for sample_capture_buf.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
// Each scenario task performs its own inline comparisons.
module tb_sample_capture_buf;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        din_valid;
  logic [15:0] din;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  sample_capture_buf #(
    .DW (16),
    .AW (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .din_valid (din_valid),
    .din       (din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] tog_val(input int k);
    return 16'(k * 3 + 'h1000);
  endfunction

  function automatic logic [15:0] mid_val(input int k);
    return 16'hA000 ^ 16'(k);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; arm = 1'b0; din_valid = 1'b0; din = '0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    // Reads and samples in IDLE are ignored.
    rst_n = 1'b1; rd_en = 1'b1; rd_addr = 9'd3; din_valid = 1'b1; din = 16'h1234;
    tick();
    rd_en = 1'b0; din_valid = 1'b0;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL idle_rd_data: got %h want 0000", rd_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_capture;
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = -1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL arm_flags: got busy=%b done=%b want busy=1 done=0", busy, done); end
    if (busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 512; i++) begin
      din_valid = 1'b1;
      din = 16'(i);
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    din_valid = 1'b0;
    vectors++; if (busy_cnt != 512) begin miscompares++; $display("FAIL busy_cycles: got %0d want 512", busy_cnt); end
    vectors++; if (done_at != 512) begin miscompares++; $display("FAIL done_edge: got write %0d want 512", done_at); end
    vectors++; if (busy !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL full_flags: got busy=%b done=%b want busy=0 done=1", busy, done); end
  endtask

  task automatic test_read_sweep;
    // Samples offered in FULL must not be stored.
    din_valid = 1'b1; din = 16'hBEEF;
    tick(); tick();
    din_valid = 1'b0;
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL full_din_flags: got busy=%b done=%b want busy=0 done=1", busy, done); end
    for (int a = 0; a < 512; a++) begin
      rd_en = 1'b1;
      rd_addr = 9'(a);
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(a)) begin
        miscompares++;
        $display("FAIL sweep_read[%0d]: got valid=%b data=%h want valid=1 data=%h", a, rd_valid, rd_data, 16'(a));
      end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL sweep_end_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 16'd511) begin miscompares++; $display("FAIL sweep_hold_data: got %h want 01ff", rd_data); end
  endtask

  task automatic test_toggle;
    int k;
    int cyc;
    int early;
    int rv_seen;
    k = 0; cyc = 0; early = 0; rv_seen = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    while (k < 512 && cyc < 2000) begin
      din_valid = (cyc % 2 == 0);
      din = din_valid ? tog_val(k) : 16'hDEAD;
      rd_en = 1'b1;
      rd_addr = 9'(k);
      tick();
      if (din_valid) k++;
      if (k < 512 && done === 1'b1) early++;
      if (rd_valid === 1'b1) rv_seen++;
      cyc++;
    end
    din_valid = 1'b0; rd_en = 1'b0;
    vectors++; if (cyc != 1023) begin miscompares++; $display("FAIL toggle_cycles: got %0d want 1023", cyc); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL toggle_early_done: got %0d cycles want 0", early); end
    vectors++; if (rv_seen != 0) begin miscompares++; $display("FAIL capture_rd_valid: got %0d cycles want 0", rv_seen); end
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL toggle_flags: got busy=%b done=%b want busy=0 done=1", busy, done); end
    vectors++; if (rd_data !== 16'd511) begin miscompares++; $display("FAIL capture_hold_data: got %h want 01ff", rd_data); end
    for (int a = 0; a < 512; a++) begin
      rd_en = 1'b1;
      rd_addr = 9'(a);
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== tog_val(a)) begin
        miscompares++;
        $display("FAIL toggle_read[%0d]: got valid=%b data=%h want valid=1 data=%h", a, rd_valid, rd_data, tog_val(a));
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_arm_with_read;
    rd_en = 1'b1; rd_addr = 9'd5; arm = 1'b1;
    tick();
    rd_en = 1'b0; arm = 1'b0;
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL rearm_rd_valid: got %b want 1", rd_valid); end
    vectors++; if (rd_data !== tog_val(5)) begin miscompares++; $display("FAIL rearm_rd_data: got %h want %h", rd_data, tog_val(5)); end
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL rearm_flags: got busy=%b done=%b want busy=1 done=0", busy, done); end
    rd_en = 1'b1; rd_addr = 9'd7;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rearm_capture_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_data !== tog_val(5)) begin miscompares++; $display("FAIL rearm_capture_hold: got %h want %h", rd_data, tog_val(5)); end
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    rv_seen = 0;
    for (int k = 0; k < 100; k++) begin
      din_valid = 1'b1;
      din = 16'h5000 + 16'(k);
      tick();
    end
    din_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL mid_flags: got busy=%b done=%b want busy=1 done=0", busy, done); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_flags: got busy=%b done=%b want busy=0 done=0", busy, done); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL midreset_rd_data: got %h want 0000", rd_data); end
    rd_en = 1'b1; rd_addr = 9'd0; din_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rd_valid === 1'b1) rv_seen++;
    end
    rd_en = 1'b0; din_valid = 1'b0;
    vectors++; if (rv_seen != 0) begin miscompares++; $display("FAIL midreset_reads: got %0d valid cycles want 0", rv_seen); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_idle: got busy=%b done=%b want busy=0 done=0", busy, done); end
  endtask

  task automatic test_arm_mid;
    int early;
    early = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 512; k++) begin
      din_valid = 1'b1;
      din = mid_val(k);
      arm = (k == 300);
      tick();
      if (k < 511 && done === 1'b1) early++;
      if (k == 300) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midarm_busy: got %b want 1", busy); end
      end
    end
    din_valid = 1'b0; arm = 1'b0;
    vectors++; if (early != 0) begin miscompares++; $display("FAIL midarm_early_done: got %0d cycles want 0", early); end
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL midarm_flags: got busy=%b done=%b want busy=0 done=1", busy, done); end
    for (int a = 0; a < 512; a++) begin
      rd_en = 1'b1;
      rd_addr = 9'(a);
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== mid_val(a)) begin
        miscompares++;
        $display("FAIL midarm_read[%0d]: got valid=%b data=%h want valid=1 data=%h", a, rd_valid, rd_data, mid_val(a));
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_capture();
    test_read_sweep();
    test_toggle();
    test_arm_with_read();
    test_reset_mid();
    test_arm_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_capture_buf.md
SAMPLE_CAPTURE_BUF -- requirements
Module: sample_capture_buf

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the sample and read-data width in bits.
REQ-002 The block SHALL have parameter AW, default 9, meaning the address width; the buffer depth is 2^AW (512 entries).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port arm, input, 1 bit, a one-cycle request to start a new capture.
REQ-006 The block SHALL have port din_valid, input, 1 bit, marking din as a valid sample this cycle.
REQ-007 The block SHALL have port din, input, DW bits, the signed DDC sample.
REQ-008 The block SHALL have port rd_en, input, 1 bit, a read request.
REQ-009 The block SHALL have port rd_addr, input, AW bits, the read address from the external 0..511 address counter.
REQ-010 The block SHALL have port rd_data, output, DW bits, the sample stored at the requested address.
REQ-011 The block SHALL have port rd_valid, output, 1 bit, qualifying rd_data for one cycle.
REQ-012 The block SHALL have port busy, output, 1 bit, high while capture is in progress.
REQ-013 The block SHALL have port done, output, 1 bit, high while a complete 512-sample record is held.

Function
REQ-014 The block SHALL implement the states IDLE, CAPTURE and FULL.
REQ-015 In IDLE with arm=1, the block SHALL enter CAPTURE on the next edge, clear wr_ptr to 0, set busy=1 and done=0.
REQ-016 In CAPTURE, each cycle with din_valid=1 SHALL write din to mem[wr_ptr] and increment wr_ptr by 1; cycles with din_valid=0 SHALL not write.
REQ-017 In CAPTURE, a write at wr_ptr=2^AW-1 SHALL move the block to FULL on the same edge, with busy=0, done=1 and wr_ptr wrapped to 0.
REQ-018 In CAPTURE, arm SHALL be ignored, with no restart and no pointer change.
REQ-019 In FULL, arm=1 SHALL restart capture exactly as in REQ-015; any read accepted in that same cycle SHALL still complete.
REQ-020 In FULL, rd_en=1 SHALL produce rd_data=mem[rd_addr] with rd_valid=1 on the next cycle (latency 1); rd_addr is unrestricted over 0..511, and back-to-back reads SHALL be supported at full rate.
REQ-021 In IDLE or CAPTURE, rd_en SHALL be ignored, with rd_valid=0 and rd_data holding its last value.
REQ-022 Memory SHALL not be written outside CAPTURE; din_valid in IDLE or FULL SHALL be dropped.
REQ-023 The block SHALL never move directly from FULL back to IDLE except through reset.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force state=IDLE, wr_ptr=0, busy=0, done=0, rd_valid=0 and rd_data=0.
REQ-025 Reset during CAPTURE SHALL abandon the record, with done remaining 0 until a full new capture completes.
REQ-026 Memory contents SHALL not be cleared by reset.

Structure
REQ-027 A shared package sample_capture_pkg SHALL hold DW, AW, DEPTH=2^AW and the state enumeration.
REQ-028 Storage SHALL be one sub-module, sample_capture_ram: a simple dual-port RAM with one synchronous write port and one synchronous registered read port, inferable as block RAM.
REQ-029 Control (FSM, wr_ptr, flags, rd_valid) SHALL reside in sample_capture_buf.

Verification
REQ-030 Reset then arm, feed din=0..511 with din_valid=1 continuously -> done rises on the edge of the 512th write; busy is high for exactly 512 cycles.
REQ-031 After REQ-030, rd_en with rd_addr sweeping 0..511 -> rd_data=rd_addr one cycle later, with rd_valid high for 512 consecutive cycles.
REQ-032 Capture with din_valid toggling 1/0 -> done only after 512 valid samples; mem[k]=k-th valid sample.
REQ-033 Assert rd_en and arm together in FULL, rd_addr=5 -> rd_valid=1 with rd_data=mem[5] next cycle, then busy=1 and done=0.
REQ-034 Apply rst_n=0 after 100 samples -> state IDLE, done=0, and rd_en gives no rd_valid until a new full capture.
REQ-035 Pulse arm mid-capture at sample 300 -> no restart; done at sample 512 with original data intact.
